// File: rtl/temporal_pkg.sv
// temporal_pkg: shared definitions for the edge-coded temporal pipeline.
// Holds the gamma-cycle phase type, the time-value width function, the
// "never fires" time constant and the idle-level helper. The encoder and the
// downstream decoder both import this package.
package temporal_pkg;

    // Gamma-cycle phase: SET clears downstream latches, COMPUTE carries edges.
    typedef enum logic [0:0] {
        PH_SET     = 1'b0,
        PH_COMPUTE = 1'b1
    } phase_t;

    // All-ones time value. Any time >= the window length never fires.
    // Users slice it down to their own time width.
    localparam logic [31:0] TIME_INF = 32'hFFFF_FFFF;

    // Width of one time value for a window of len clocks. The extra bit
    // leaves room for values at or beyond the window end (infinity).
    function automatic int time_w(input int len);
        return $clog2(len) + 1;
    endfunction

    // Level a channel rests at before its edge: low for rising edges,
    // high for falling edges.
    function automatic logic idle_level(input logic falling);
        return falling ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/temporal_encoder_gamma_cycle_timer.sv
// gamma_cycle_timer: phase/counter state machine for one gamma cycle.
// Runs SET for PULSE_WIDTH clocks, then COMPUTE for GAMMA_CYCLE_WIDTH clocks,
// forever. Its state runs one clock ahead of the encoder's registered outputs:
// the state held here is the cycle the encoder outputs will show after the
// next clock edge. Reset parks it at SET index 0, so the first clock after
// reset releases shows SET cycle 0 on the encoder outputs.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   phase        phase of the upcoming output cycle
//   k            compute index of the upcoming cycle (0 outside COMPUTE)
//   gamma_start  upcoming cycle is the first SET cycle
//   gamma_done   upcoming cycle is the last COMPUTE cycle
//   load_now     the current output cycle is the last SET cycle
module gamma_cycle_timer
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    localparam int TIME_W           = time_w(GAMMA_CYCLE_WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    output phase_t            phase,
    output logic [TIME_W-1:0] k,
    output logic              gamma_start,
    output logic              gamma_done,
    output logic              load_now
);

    localparam int MAX_LEN = (PULSE_WIDTH > GAMMA_CYCLE_WIDTH) ? PULSE_WIDTH : GAMMA_CYCLE_WIDTH;
    localparam int CNT_W   = time_w(MAX_LEN);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CMP_LAST = CNT_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    phase_t           phase_r;
    phase_t           phase_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // State register: phase and in-phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= PH_SET;
            cnt_r   <= CNT_ZERO;
        end else begin
            phase_r <= phase_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: the counter wraps only at the end of each phase.
    always_comb begin
        phase_nxt_s = phase_r;
        cnt_nxt_s   = cnt_r + CNT_ONE;
        case (phase_r)
            PH_SET: begin
                if (cnt_r == SET_LAST) begin
                    phase_nxt_s = PH_COMPUTE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    phase_nxt_s = PH_SET;
                end
            end
            PH_COMPUTE: begin
                if (cnt_r == CMP_LAST) begin
                    phase_nxt_s = PH_SET;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    phase_nxt_s = PH_COMPUTE;
                end
            end
            default: begin
                phase_nxt_s = PH_SET;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode of the lookahead state.
    always_comb begin
        phase       = phase_r;
        k           = {TIME_W{1'b0}};
        gamma_start = 1'b0;
        gamma_done  = 1'b0;
        load_now    = 1'b0;
        if (phase_r == PH_COMPUTE) begin
            k          = cnt_r[TIME_W-1:0];
            gamma_done = (cnt_r == CMP_LAST);
            // Upcoming cycle is COMPUTE 0, so the current one is the last SET cycle.
            load_now   = (cnt_r == CNT_ZERO);
        end else begin
            gamma_start = (cnt_r == CNT_ZERO);
        end
    end

endmodule

// File: rtl/temporal_encoder.sv
// temporal_encoder: converts binary time values into per-channel temporal
// edges inside a gamma cycle. Each gamma cycle is a SET phase (set_out high,
// edges idle) followed by a COMPUTE window in which channel ch leaves its idle
// level at compute index t[ch] and stays there until the next SET phase.
// One vector is accepted per gamma cycle through a one-deep pending buffer,
// which is moved into the active registers on the last SET cycle.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   in_valid      input vector valid
//   in_ready      encoder can accept a vector this cycle (combinational)
//   in_time       packed edge times, channel 0 in the LSBs
//   set_out       latch-clear pulse for downstream comparators
//   edge_out      edge-coded channel outputs
//   gamma_start   one-cycle pulse on the first SET cycle
//   gamma_done    one-cycle pulse on the last COMPUTE cycle
//   cycle_loaded  current COMPUTE window carries real data
module temporal_encoder
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CH            = 2,
    parameter int FALLING           = 0,
    localparam int TIME_W           = time_w(GAMMA_CYCLE_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*TIME_W-1:0] in_time,
    output logic                     set_out,
    output logic [NUM_CH-1:0]        edge_out,
    output logic                     gamma_start,
    output logic                     gamma_done,
    output logic                     cycle_loaded
);

    localparam logic              IDLE     = idle_level(FALLING != 0);
    localparam logic [NUM_CH-1:0] IDLE_VEC = {NUM_CH{IDLE}};

    phase_t                     tmr_phase_s;
    logic [TIME_W-1:0]          tmr_k_s;
    logic                       tmr_start_s;
    logic                       tmr_done_s;
    logic                       load_now_s;

    logic [NUM_CH*TIME_W-1:0]   pending_r;
    logic                       pending_full_r;
    logic [NUM_CH*TIME_W-1:0]   active_r;
    logic                       cycle_loaded_r;

    logic                       in_ready_s;
    logic                       accept_s;
    logic                       pending_full_nxt_s;
    logic                       loaded_nxt_s;
    logic [NUM_CH*TIME_W-1:0]   time_nxt_s;
    logic [NUM_CH-1:0]          edge_nxt_s;

    gamma_cycle_timer #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
        .PULSE_WIDTH       (PULSE_WIDTH)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .phase       (tmr_phase_s),
        .k           (tmr_k_s),
        .gamma_start (tmr_start_s),
        .gamma_done  (tmr_done_s),
        .load_now    (load_now_s)
    );

    // Handshake and buffer control. On the last SET cycle the pending slot
    // empties into the active registers, so it can take a new vector that
    // same cycle.
    always_comb begin
        in_ready_s         = (!reset) && ((!pending_full_r) || load_now_s);
        accept_s           = in_valid && in_ready_s;
        pending_full_nxt_s = pending_full_r;
        if (load_now_s) begin
            pending_full_nxt_s = accept_s;
        end else if (accept_s) begin
            pending_full_nxt_s = 1'b1;
        end else begin
            pending_full_nxt_s = pending_full_r;
        end
    end

    // Window data for the upcoming cycle. On the load edge the comparators
    // must already see the pending vector so that t=0 fires at compute index 0.
    always_comb begin
        loaded_nxt_s = cycle_loaded_r;
        time_nxt_s   = active_r;
        if (tmr_phase_s == PH_SET) begin
            loaded_nxt_s = 1'b0;
        end else if (load_now_s) begin
            loaded_nxt_s = pending_full_r;
            time_nxt_s   = pending_r;
        end else begin
            loaded_nxt_s = cycle_loaded_r;
        end
    end

    // Per-channel comparators: a channel is non-idle once k reaches its time.
    // k never exceeds G-1, so any time >= G never fires.
    always_comb begin
        edge_nxt_s = IDLE_VEC;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (loaded_nxt_s && (tmr_phase_s == PH_COMPUTE) &&
                (tmr_k_s >= time_nxt_s[ch*TIME_W +: TIME_W])) begin
                edge_nxt_s[ch] = ~IDLE;
            end else begin
                edge_nxt_s[ch] = IDLE;
            end
        end
    end

    // Buffer registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r      <= {(NUM_CH*TIME_W){1'b0}};
            pending_full_r <= 1'b0;
            active_r       <= {(NUM_CH*TIME_W){1'b0}};
            cycle_loaded_r <= 1'b0;
            set_out        <= 1'b0;
            edge_out       <= IDLE_VEC;
            gamma_start    <= 1'b0;
            gamma_done     <= 1'b0;
        end else begin
            if (load_now_s && pending_full_r) begin
                active_r <= pending_r;
            end
            if (accept_s) begin
                pending_r <= in_time;
            end
            pending_full_r <= pending_full_nxt_s;
            cycle_loaded_r <= loaded_nxt_s;
            set_out        <= (tmr_phase_s == PH_SET);
            edge_out       <= edge_nxt_s;
            gamma_start    <= tmr_start_s;
            gamma_done     <= tmr_done_s;
        end
    end

    assign in_ready     = in_ready_s;
    assign cycle_loaded = cycle_loaded_r;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder with G=16, P=8, two channels.
// dut0 uses rising edges, dut1 falling edges. Cycle n is the clock period
// after the n-th rising edge following reset release; outputs are checked
// and inputs driven 1 time unit after that edge.
module tb_temporal_encoder;

    logic       clk = 1'b0;
    logic       reset0, reset1;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1;
    logic [9:0] in_time0, in_time1;
    logic       set0, set1;
    logic [1:0] edge0, edge1;
    logic       gs0, gs1, gd0, gd1, ld0, ld1;

    int cyc      = -100;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    temporal_encoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .NUM_CH(2), .FALLING(0)) dut0 (
        .clk(clk), .reset(reset0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_time(in_time0), .set_out(set0), .edge_out(edge0),
        .gamma_start(gs0), .gamma_done(gd0), .cycle_loaded(ld0)
    );

    temporal_encoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .NUM_CH(2), .FALLING(1)) dut1 (
        .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_time(in_time1), .set_out(set1), .edge_out(edge1),
        .gamma_start(gs1), .gamma_done(gd1), .cycle_loaded(ld1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        reset0 = 1'b1; reset1 = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_time0 = 10'd0; in_time1 = 10'd0;
        repeat (3) tick();
        check_eq("rst_set0",   {31'd0, set0},      32'd0);
        check_eq("rst_edge0",  {30'd0, edge0},     32'd0);
        check_eq("rst_edge1",  {30'd0, edge1},     32'd3);
        check_eq("rst_gs0",    {31'd0, gs0},       32'd0);
        check_eq("rst_gd0",    {31'd0, gd0},       32'd0);
        check_eq("rst_ld0",    {31'd0, ld0},       32'd0);
        check_eq("rst_ready0", {31'd0, in_ready0}, 32'd0);
        check_eq("rst_ready1", {31'd0, in_ready1}, 32'd0);
        reset0 = 1'b0; reset1 = 1'b0;
        cyc = -1;

        // ---------------- Segment A ----------------
        run_to(0);
        check_eq("c0_gs0",    {31'd0, gs0},       32'd1);
        check_eq("c0_set0",   {31'd0, set0},      32'd1);
        check_eq("c0_ready0", {31'd0, in_ready0}, 32'd1);
        check_eq("c0_edge1",  {30'd0, edge1},     32'd3);
        check_eq("c0_set1",   {31'd0, set1},      32'd1);
        run_to(2);
        in_valid0 = 1'b1; in_time0 = {5'd5, 5'd3};
        run_to(3);
        in_valid0 = 1'b0;
        check_eq("c3_ready0", {31'd0, in_ready0}, 32'd0);
        in_valid1 = 1'b1; in_time1 = {5'd31, 5'd4};
        run_to(4);
        in_valid1 = 1'b0;
        run_to(7);
        check_eq("c7_set0",   {31'd0, set0},      32'd1);
        check_eq("c7_ready0", {31'd0, in_ready0}, 32'd1);
        run_to(8);
        check_eq("c8_set0",   {31'd0, set0},      32'd0);
        check_eq("c8_ld0",    {31'd0, ld0},       32'd1);
        check_eq("c8_edge0",  {30'd0, edge0},     32'd0);
        check_eq("c8_edge1",  {30'd0, edge1},     32'd3);
        check_eq("c8_ld1",    {31'd0, ld1},       32'd1);
        run_to(10);
        check_eq("c10_edge0", {30'd0, edge0},     32'd0);
        run_to(11);
        check_eq("c11_edge0", {30'd0, edge0},     32'd1);
        check_eq("c11_edge1", {30'd0, edge1},     32'd3);
        run_to(12);
        check_eq("c12_edge1", {30'd0, edge1},     32'd2);
        run_to(13);
        check_eq("c13_edge0", {30'd0, edge0},     32'd3);
        run_to(22);
        check_eq("c22_gd0",   {31'd0, gd0},       32'd0);
        run_to(23);
        check_eq("c23_gd0",   {31'd0, gd0},       32'd1);
        check_eq("c23_edge0", {30'd0, edge0},     32'd3);
        check_eq("c23_edge1", {30'd0, edge1},     32'd2);
        run_to(24);
        check_eq("c24_set0",  {31'd0, set0},      32'd1);
        check_eq("c24_gs0",   {31'd0, gs0},       32'd1);
        check_eq("c24_gd0",   {31'd0, gd0},       32'd0);
        check_eq("c24_edge0", {30'd0, edge0},     32'd0);
        check_eq("c24_ld0",   {31'd0, ld0},       32'd0);
        check_eq("c24_edge1", {30'd0, edge1},     32'd3);
        run_to(25);
        in_valid0 = 1'b1; in_time0 = {5'd31, 5'd0};
        in_valid1 = 1'b1; in_time1 = {5'd0, 5'd4};
        run_to(26);
        // Values were captured last cycle; scribble over the bus.
        in_valid0 = 1'b0; in_time0 = 10'h3FF;
        in_valid1 = 1'b0; in_time1 = 10'h3FF;
        check_eq("c26_ready0", {31'd0, in_ready0}, 32'd0);
        run_to(31);
        check_eq("c31_set0",  {31'd0, set0},      32'd1);
        check_eq("c31_edge0", {30'd0, edge0},     32'd0);
        run_to(32);
        check_eq("c32_set0",  {31'd0, set0},      32'd0);
        check_eq("c32_edge0", {30'd0, edge0},     32'd1);
        check_eq("c32_ld0",   {31'd0, ld0},       32'd1);
        check_eq("c32_edge1", {30'd0, edge1},     32'd1);
        run_to(36);
        check_eq("c36_edge1",  {30'd0, edge1},     32'd0);
        check_eq("c36_ready1", {31'd0, in_ready1}, 32'd1);
        in_valid1 = 1'b1; in_time1 = 10'd0;
        run_to(37);
        in_valid1 = 1'b0;
        run_to(38);
        check_eq("c38_edge1", {30'd0, edge1},     32'd0);
        reset1 = 1'b1;
        run_to(39);
        check_eq("c39_edge1",  {30'd0, edge1},     32'd3);
        check_eq("c39_set1",   {31'd0, set1},      32'd0);
        check_eq("c39_ld1",    {31'd0, ld1},       32'd0);
        check_eq("c39_ready1", {31'd0, in_ready1}, 32'd0);
        check_eq("c39_gs1",    {31'd0, gs1},       32'd0);
        run_to(40);
        check_eq("c40_set1",  {31'd0, set1},      32'd0);
        reset1 = 1'b0;
        run_to(41);
        check_eq("c41_set1",   {31'd0, set1},      32'd1);
        check_eq("c41_gs1",    {31'd0, gs1},       32'd1);
        check_eq("c41_edge1",  {30'd0, edge1},     32'd3);
        check_eq("c41_ready1", {31'd0, in_ready1}, 32'd1);
        run_to(47);
        check_eq("c47_edge0", {30'd0, edge0},     32'd1);
        check_eq("c47_gd0",   {31'd0, gd0},       32'd1);
        run_to(48);
        check_eq("c48_set0",  {31'd0, set0},      32'd1);
        check_eq("c48_gs0",   {31'd0, gs0},       32'd1);
        check_eq("c48_edge0", {30'd0, edge0},     32'd0);
        check_eq("c48_ld0",   {31'd0, ld0},       32'd0);
        check_eq("c48_set1",  {31'd0, set1},      32'd1);
        run_to(49);
        check_eq("c49_set1",  {31'd0, set1},      32'd0);
        check_eq("c49_ld1",   {31'd0, ld1},       32'd0);
        check_eq("c49_edge1", {30'd0, edge1},     32'd3);
        run_to(56);
        check_eq("c56_ld0",   {31'd0, ld0},       32'd0);
        check_eq("c56_set0",  {31'd0, set0},      32'd0);
        check_eq("c56_edge0", {30'd0, edge0},     32'd0);
        check_eq("c56_edge1", {30'd0, edge1},     32'd3);
        run_to(60);
        check_eq("c60_edge0", {30'd0, edge0},     32'd0);
        run_to(64);
        check_eq("c64_gd1",   {31'd0, gd1},       32'd1);
        run_to(71);
        check_eq("c71_gd0",   {31'd0, gd0},       32'd1);
        check_eq("c71_edge0", {30'd0, edge0},     32'd0);
        run_to(72);
        check_eq("c72_set0",  {31'd0, set0},      32'd1);
        check_eq("c72_gs0",   {31'd0, gs0},       32'd1);

        // ---------------- Segment B: back-to-back ----------------
        reset0 = 1'b1; reset1 = 1'b1;
        run_to(74);
        check_eq("b_rst_set0", {31'd0, set0}, 32'd0);
        reset0 = 1'b0; reset1 = 1'b0;
        cyc = -1;
        run_to(0);
        check_eq("b0_gs0", {31'd0, gs0}, 32'd1);
        run_to(1);
        in_valid0 = 1'b1; in_time0 = {5'd7, 5'd1};
        check_eq("b1_ready0", {31'd0, in_ready0}, 32'd1);
        run_to(2);
        in_time0 = {5'd2, 5'd9};
        check_eq("b2_ready0", {31'd0, in_ready0}, 32'd0);
        run_to(6);
        check_eq("b6_ready0", {31'd0, in_ready0}, 32'd0);
        run_to(7);
        check_eq("b7_ready0", {31'd0, in_ready0}, 32'd1);
        run_to(8);
        in_time0 = {5'd15, 5'd14};
        check_eq("b8_ready0", {31'd0, in_ready0}, 32'd0);
        check_eq("b8_edge0",  {30'd0, edge0},     32'd0);
        check_eq("b8_ld0",    {31'd0, ld0},       32'd1);
        run_to(9);
        check_eq("b9_edge0",  {30'd0, edge0},     32'd1);
        run_to(15);
        check_eq("b15_edge0", {30'd0, edge0},     32'd3);
        run_to(31);
        check_eq("b31_ready0", {31'd0, in_ready0}, 32'd1);
        run_to(32);
        in_valid0 = 1'b0;
        check_eq("b32_ready0", {31'd0, in_ready0}, 32'd0);
        check_eq("b32_edge0",  {30'd0, edge0},     32'd0);
        check_eq("b32_ld0",    {31'd0, ld0},       32'd1);
        run_to(34);
        check_eq("b34_edge0", {30'd0, edge0},     32'd2);
        run_to(41);
        check_eq("b41_edge0", {30'd0, edge0},     32'd3);
        run_to(56);
        check_eq("b56_ld0",   {31'd0, ld0},       32'd1);
        check_eq("b56_edge0", {30'd0, edge0},     32'd0);
        run_to(69);
        check_eq("b69_edge0", {30'd0, edge0},     32'd0);
        run_to(70);
        check_eq("b70_edge0", {30'd0, edge0},     32'd1);
        run_to(71);
        check_eq("b71_edge0", {30'd0, edge0},     32'd3);
        run_to(72);
        check_eq("b72_edge0", {30'd0, edge0},     32'd0);
        check_eq("b72_set0",  {31'd0, set0},      32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/temporal_encoder.md
Name: temporal_encoder

Overview:
- Upstream stage of the edge-coded comparators (not_equal and siblings). Converts binary time values into per-channel temporal edges within a gamma cycle.
- Owns the gamma-cycle timing. Generates the `set` pulse that clears downstream SR latches, then a compute window in which each channel makes one monotonic transition at its encoded time.
- Accepts one input vector per gamma cycle over a valid/ready handshake, using a one-deep pending buffer.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, compute-window length in clocks. Legal: >=2.
- PULSE_WIDTH, 8, set-phase length in clocks. Legal: >=1.
- NUM_CH, 2, number of encoded channels.
- FALLING, 0, edge polarity. 0: idle low, edge rises. 1: idle high, edge falls.
- TIME_W (localparam), $clog2(GAMMA_CYCLE_WIDTH)+1, width of one time value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  encoder can accept a vector this cycle
- in_time  in  NUM_CH*TIME_W  packed edge times, channel 0 in the LSBs
- set_out  out  1  latch-clear pulse, drives the `set` input of downstream comparators
- edge_out  out  NUM_CH  edge-coded channel outputs
- gamma_start  out  1  one-cycle pulse on the first set-phase cycle
- gamma_done  out  1  one-cycle pulse on the last compute cycle
- cycle_loaded  out  1  current compute window carries real data

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All outputs are registered except in_ready.
- Reset values, held while reset=1: set_out=0, edge_out=idle level (all 0 if FALLING=0, all 1 if FALLING=1), gamma_start=0, gamma_done=0, cycle_loaded=0. Pending buffer and active registers are cleared; in_ready=0 while reset=1.
- States:
  - SET: PULSE_WIDTH cycles. set_out=1, edge_out idle.
  - COMPUTE: GAMMA_CYCLE_WIDTH cycles, compute index k=0..G-1.
  - Transitions: SET -> COMPUTE -> SET, repeating indefinitely.
- Gamma period is PULSE_WIDTH+GAMMA_CYCLE_WIDTH clocks.
- The first clock after reset deasserts is SET cycle 0, with gamma_start=1.
- Edge rule: in COMPUTE index k, edge_out[ch] is non-idle iff cycle_loaded and k >= t[ch].
  - t=0 transitions in the same cycle set_out falls.
  - Any t >= GAMMA_CYCLE_WIDTH (e.g. all-ones) is infinity: the channel never transitions.
  - Outputs return to idle on the first cycle of the next SET phase.
- Transitions are monotonic: at most one per channel per gamma cycle, and no glitching in COMPUTE.
- Handshake:
  - A transfer occurs when in_valid && in_ready at a rising clk edge.
  - in_ready = !pending_full || load_now. load_now is true on the last SET cycle.
- Load: on the last SET-cycle edge:
  - If pending_full, move pending into active, set cycle_loaded=1, and clear pending.
  - Otherwise set cycle_loaded=0 for the coming window and hold edge_out idle throughout.
- Simultaneous load and accept: the old pending value goes to active and the new vector goes to pending. pending_full stays 1.
- in_time must be stable only in the accept cycle. Values are captured and never re-sampled.
- cycle_loaded updates on the SET->COMPUTE boundary and holds through COMPUTE. It is cleared at SET entry.
- Reset mid-operation: pending and active data are discarded with no partial edges. Timing restarts at SET cycle 0 after release.
- The counter wraps only at phase ends. No off-by-one is permitted: SET is exactly PULSE_WIDTH cycles and COMPUTE exactly GAMMA_CYCLE_WIDTH cycles.

Decomposition:
- Shared package temporal_pkg:
  - phase_t enum {PH_SET, PH_COMPUTE}
  - localparam function for TIME_W
  - TIME_INF constant (all-ones)
  - edge idle-level helper keyed by FALLING
  - These are reused by the downstream temporal_decoder.
- Sub-module gamma_cycle_timer (state plus counter) outputs: phase, compute index k, gamma_start, gamma_done, load_now.
- temporal_encoder instantiates gamma_cycle_timer, plus the pending/active registers and per-channel comparators.

Test Plan:
- Reset released with G=16, P=8 -> gamma_start at cycle 0; set_out=1 for cycles 0–7, 0 for cycles 8–23; gamma_done at cycle 23; set_out=1 again at cycle 24.
- Accept in_time={ch1=5, ch0=3} at cycle 2 (FALLING=0) -> cycle_loaded=1 for cycles 8–23; edge_out[0] rises at cycle 11, edge_out[1] at cycle 13; both fall at cycle 24.
- in_time={ch1=31, ch0=0} -> edge_out[0] high cycles 8–23; edge_out[1] stays 0 for the whole window.
- No input offered -> cycle_loaded=0; edge_out stays idle for the window; set_out still pulses each period.
- Back-to-back vectors V1, V2, V3 with in_valid held high from cycle 1:
  - V1 accepted at cycle 1; in_ready low cycles 2–6.
  - V2 accepted at cycle 7 (load_now) while V1 loads.
  - V3 accepted at cycle 31.
  - V2 drives the second window, V3 the third.
- FALLING=1 with t=4, plus reset asserted at compute index 6 of the next window:
  - edge_out idle=1, falls at cycle 12.
  - On reset, all outputs return to reset values the next cycle; after release, SET restarts with pending empty.
